// File: rtl/arb_pkg.sv
// Shared types, defaults and helpers for the round-robin grant arbiter.
package arb_pkg;

    localparam int unsigned DEF_NUM_REQ  = 4;
    localparam int unsigned DEF_MAX_HOLD = 8;
    localparam int unsigned MAX_REQ      = 16;
    localparam int unsigned MAX_IDW      = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Rotate the low 'width' bits of vec right by amt: res[j] = vec[(j+amt) % width].
    function automatic logic [MAX_REQ-1:0] rot_right(
        input logic [MAX_REQ-1:0] vec,
        input int unsigned        width,
        input int unsigned        amt
    );
        logic [MAX_REQ-1:0] res;
        res = '0;
        for (int unsigned j = 0; j < MAX_REQ; j++) begin
            if (j < width) begin
                res[MAX_IDW'(j)] = vec[MAX_IDW'((j + amt) % width)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prio_sel_n.sv
// Combinational fixed-priority selector: highest-index set bit wins.
module prio_sel_n #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] sel,
    output logic               valid
);

    // Scan from the top bit down and keep only the first hit.
    always_comb begin
        sel   = '0;
        valid = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && !(|sel)) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with registered one-hot grant.
// Optional build macro ARB_HOLD_LIMIT_EN: preempts an owner after MAX_HOLD
// consecutive grant cycles when another requester is waiting.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       req_up
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || MAX_HOLD < 1) begin : g_bad_param
        $error("rr_grant_arbiter: unsupported NUM_REQ/MAX_HOLD");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               gnt_valid_q;
    logic [IDW-1:0]     ptr_q, ptr_d;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HCW-1:0] hold_q, hold_d;
`endif

    logic [NUM_REQ-1:0] rot_req, rot_sel, win_gnt;
    logic               win_valid;
    logic [IDW-1:0]     win_id;
    logic               own_req, others, issue;

    // Rotate requests so the pointer position lands on the top (highest-priority) bit.
    always_comb begin
        rot_req = NUM_REQ'(rot_right(MAX_REQ'(req), NUM_REQ, int'(ptr_q) + 1));
    end

    prio_sel_n #(.NUM_REQ(NUM_REQ)) u_prio_sel (
        .req   (rot_req),
        .sel   (rot_sel),
        .valid (win_valid)
    );

    // Undo the rotation and encode the winner index.
    always_comb begin
        win_gnt = NUM_REQ'(rot_right(MAX_REQ'(rot_sel), NUM_REQ,
                                     NUM_REQ - ((int'(ptr_q) + 1) % NUM_REQ)));
        win_id  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                win_id = IDW'(i);
            end
        end
    end

    // Next-state, next-grant and pointer logic.
    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        gnt_id_d = '0;
        ptr_d    = ptr_q;
        issue    = 1'b0;
        own_req  = |(req & gnt_q);
        others   = |(req & ~gnt_q);
`ifdef ARB_HOLD_LIMIT_EN
        hold_d   = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (en && win_valid) begin
                    issue = 1'b1;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (own_req) begin
                    gnt_d    = gnt_q;
                    gnt_id_d = gnt_id_q;
`ifdef ARB_HOLD_LIMIT_EN
                    if (hold_q == HCW'(MAX_HOLD - 1)) begin
                        // Pointer already sits below the owner, so the winner is another requester.
                        issue = others;
                    end else begin
                        hold_d = hold_q + HCW'(1);
                    end
`endif
                end else if (win_valid) begin
                    issue = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            state_d  = GRANT;
            gnt_d    = win_gnt;
            gnt_id_d = win_id;
            ptr_d    = IDW'(win_id - IDW'(1));
`ifdef ARB_HOLD_LIMIT_EN
            hold_d   = '0;
`endif
        end
    end

    // State, grant and pointer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= IDW'(NUM_REQ - 1);
`ifdef ARB_HOLD_LIMIT_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= |gnt_d;
            ptr_q       <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign req_up    = en & (|req);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter against a behavioural round-robin model.
module tb_rr_grant_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic         en;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         req_up;

    int nvec = 0;
    int nerr = 0;

    // Reference model state: current owner (-1 none), highest-priority index, hold count.
    int m_owner;
    int m_ptr;
    int m_hold;

    rr_grant_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .en        (en),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .req_up    (req_up)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Search downward from the pointer, wrapping, for the first active request.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr - k + N) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_grant(input logic [N-1:0] r);
        m_owner = pick(r, m_ptr);
        m_ptr   = (m_owner - 1 + N) % N;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic e);
        logic [N-1:0] oth;
        oth = r;
        if (m_owner >= 0) oth[m_owner] = 1'b0;
        if (!e) begin
            m_owner = -1;
        end else if (m_owner >= 0 && r[m_owner]) begin
            if (HOLD_EN && m_hold == MAX_HOLD - 1) begin
                if (oth != '0) model_grant(r);
            end else begin
                m_hold++;
            end
        end else if (r != '0) begin
            model_grant(r);
        end else begin
            m_owner = -1;
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic check_outputs(input string tag);
        logic [N-1:0] eg;
        eg = exp_gnt();
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_valid"}, 32'(gnt_valid), 32'(eg != '0));
        check({tag, "_id"}, 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input logic [N-1:0] r, input logic e, input string tag);
        req = r;
        en  = e;
        #1;
        check({tag, "_req_up"}, 32'(req_up), 32'(e & (|r)));
        model_step(r, e);
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input logic [N-1:0] r, input logic e, input string tag);
        reset = 1'b1;
        req   = r;
        en    = e;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        m_owner = -1;
        m_ptr   = N - 1;
        m_hold  = 0;
        check_outputs(tag);
    endtask

    initial begin
        logic [N-1:0] r;
        logic         e;
        logic [N-1:0] prev_r;

        reset = 1'b1;
        req   = '0;
        en    = 1'b0;
        @(posedge clock);
        #1;
        do_reset('0, 1'b0, "reset");

        // First grant and hand-off without a bubble.
        step(4'b1111, 1'b1, "first");
        check("first_const", 32'(gnt), 32'(4'b1000));
        step(4'b0111, 1'b1, "handoff");
        check("handoff_const", 32'(gnt), 32'(4'b0100));

        // Rotation order 3,2,1,0,3 with each owner dropping after one cycle.
        do_reset('0, 1'b0, "reset2");
        step(4'b1111, 1'b1, "rot3");
        step(4'b0111, 1'b1, "rot2");
        step(4'b1011, 1'b1, "rot1");
        check("rot1_const", 32'(gnt), 32'(4'b0010));
        step(4'b1101, 1'b1, "rot0");
        check("rot0_const", 32'(gnt), 32'(4'b0001));
        step(4'b1110, 1'b1, "rot3b");
        check("rot3b_const", 32'(gnt), 32'(4'b1000));

        // Owner 1, then enable low, then re-enable with 0011 -> requester 0.
        step(4'b0010, 1'b1, "own1");
        check("own1_const", 32'(gnt), 32'(4'b0010));
        step(4'b0011, 1'b0, "en_low");
        check("en_low_const", 32'(gnt_valid), 32'd0);
        step(4'b0011, 1'b0, "en_low_idle");
        step(4'b0011, 1'b1, "en_back");
        check("en_back_const", 32'(gnt), 32'(4'b0001));

        // Reset while requester 2 is granted.
        step(4'b0100, 1'b1, "own2");
        check("own2_const", 32'(gnt), 32'(4'b0100));
        do_reset(4'b1111, 1'b1, "midreset");
        step(4'b1111, 1'b1, "after_reset");
        check("after_reset_const", 32'(gnt), 32'(4'b1000));

        // No requests with enable high, and a long hold by one owner.
        step(4'b0000, 1'b1, "no_req");
        step(4'b0000, 1'b1, "no_req2");
        for (int i = 0; i < 12; i++) step(4'b0100, 1'b1, "hold2");
        step(4'b0110, 1'b1, "hold2_contend");

`ifdef ARB_HOLD_LIMIT_EN
        // Hold limit: owner 3 keeps 8 cycles then yields to 0; sole requester holds forever.
        do_reset('0, 1'b0, "reset_hl");
        for (int i = 0; i < MAX_HOLD; i++) begin
            step(4'b1001, 1'b1, "hl_owner3");
            check("hl_owner3_const", 32'(gnt), 32'(4'b1000));
        end
        step(4'b1001, 1'b1, "hl_preempt");
        check("hl_preempt_const", 32'(gnt), 32'(4'b0001));
        step(4'b1000, 1'b1, "hl_solo_take");
        for (int i = 0; i < 3 * MAX_HOLD; i++) begin
            step(4'b1000, 1'b1, "hl_solo");
            check("hl_solo_const", 32'(gnt), 32'(4'b1000));
        end
`endif

        // Randomised traffic with structural checks.
        do_reset('0, 1'b0, "reset_rand");
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
            e = ($urandom_range(0, 9) != 0);
            prev_r = r;
            step(r, e, "rand");
            check("rand_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("rand_subset", 32'(gnt & ~prev_r), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
